// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and I-cache.
// One request at a time; mem_addr is held by the master until mem_valid returns.
interface fetch_stage_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_valid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_valid, mem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// PC owner feeding IF/ID: zero-latency on hits, NOP bubbles on misses, one request outstanding.
// Stall parks a hit in a hold buffer; a redirect during a miss waits out the owed response first.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_in,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        mem,
  output logic [31:0]          pc_out,
  output logic [31:0]          instruction_out,
  output logic                 fetch_valid,
  output logic                 flush_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] pc_inc;

  assign pc_inc    = pc_q + 32'd4;
  assign pc_out    = pc_q;
  assign flush_out = redirect_valid;
  // Address is pinned to the PC in every state so it cannot move while a response is owed.
  assign mem.mem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'h0;
      hold_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_pc_d       = pend_pc_q;
    hold_instr_d    = hold_instr_q;
    mem.mem_req     = 1'b0;
    fetch_valid     = 1'b0;
    instruction_out = NOP_INSTR;

    case (state_q)
      S_REQ: begin
        mem.mem_req = 1'b1;
        if (mem.mem_valid) begin
          fetch_valid     = 1'b1;
          instruction_out = mem.mem_rdata;
        end
        if (redirect_valid) begin
          if (mem.mem_valid) begin
            pc_d = redirect_pc;
          end else begin
            pend_pc_d = redirect_pc;
            state_d   = S_DROP;
          end
        end else if (mem.mem_valid && !stall_in) begin
          pc_d = pc_inc;
        end else if (mem.mem_valid) begin
          hold_instr_d = mem.mem_rdata;
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        fetch_valid     = 1'b1;
        instruction_out = hold_instr_q;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (!stall_in) begin
          pc_d    = pc_inc;
          state_d = S_REQ;
        end
      end

      S_DROP: begin
        mem.mem_req = 1'b1;
        if (redirect_valid) begin
          pend_pc_d = redirect_pc;
        end
        // A redirect landing with the response must win over the older pending target.
        if (mem.mem_valid) begin
          pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    if (reset) begin
      mem.mem_req     = 1'b0;
      fetch_valid     = 1'b0;
      instruction_out = NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed test-plan scenarios then random traffic, scored against a behavioural fetch model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        fetch_valid;
  logic        flush_out;

  fetch_stage_if mif ();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .mem             (mif),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .fetch_valid     (fetch_valid),
    .flush_out       (flush_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          fv;
    logic [31:0] instr;
    logic [31:0] pc;
    bit          pc_known;
    bit          flush;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model: the PC, a parked instruction, and an owed response whose target is deferred.
  logic [31:0] m_pc    = 32'h0;
  bit          m_known = 1'b0;
  bit          m_parked = 1'b0;
  logic [31:0] m_parked_instr = 32'h0;
  bit          m_owed  = 1'b0;
  logic [31:0] m_target = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; mem_valid is suppressed when the model says no request is outstanding.
  task automatic step(input bit rst, input bit st, input bit rv, input logic [31:0] rpc,
                      input bit mv, input logic [31:0] rd);
    exp_t e;
    bit   requesting;
    bit   mv_eff;
    @(negedge clk);
    requesting = !rst && !m_parked;
    mv_eff     = mv && requesting;
    reset          = rst;
    stall_in       = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    mif.mem_valid  = mv_eff;
    mif.mem_rdata  = rd;

    e.req      = requesting;
    e.addr     = m_pc;
    e.pc       = m_pc;
    e.pc_known = m_known;
    e.flush    = rv;
    if (rst) begin
      e.fv = 1'b0; e.instr = NOP_INSTR;
    end else if (m_parked) begin
      e.fv = 1'b1; e.instr = m_parked_instr;
    end else if (m_owed) begin
      e.fv = 1'b0; e.instr = NOP_INSTR;
    end else begin
      e.fv = mv_eff; e.instr = mv_eff ? rd : NOP_INSTR;
    end
    exp_q.push_back(e);

    if (rst) begin
      m_pc = RESET_PC; m_known = 1'b1; m_parked = 1'b0; m_owed = 1'b0;
    end else if (m_parked) begin
      if (rv) begin m_pc = rpc; m_parked = 1'b0; end
      else if (!st) begin m_pc = m_pc + 32'd4; m_parked = 1'b0; end
    end else if (m_owed) begin
      if (rv) m_target = rpc;
      if (mv_eff) begin m_pc = m_target; m_owed = 1'b0; end
    end else if (rv) begin
      if (mv_eff) m_pc = rpc;
      else begin m_target = rpc; m_owed = 1'b1; end
    end else if (mv_eff) begin
      if (st) begin m_parked = 1'b1; m_parked_instr = rd; end
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic hit(input logic [31:0] rd);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, rd);
  endtask

  task automatic miss();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hBAD0_BAD0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_req", {31'h0, mif.mem_req}, {31'h0, e.req});
        if (e.req) chk("mem_addr", mif.mem_addr, e.addr);
        chk("fetch_valid", {31'h0, fetch_valid}, {31'h0, e.fv});
        chk("instruction_out", instruction_out, e.instr);
        if (e.pc_known) chk("pc_out", pc_out, e.pc);
        chk("flush_out", {31'h0, flush_out}, {31'h0, e.flush});
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mif.mem_valid = 1'b0; mif.mem_rdata = 32'h0;

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    // Back-to-back hits 0,4 then a 3-cycle miss at 8.
    hit(32'h1111_0000); hit(32'h1111_0004);
    miss(); miss(); miss();
    hit(32'h1111_0008);
    // Stall on a hit at C, hold for two cycles, release.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    // Miss at 10, redirect to 100 then 200 before the response arrives.
    miss();
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    miss();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    hit(32'h2222_0200);
    // Redirect coincident with a hit in REQ.
    step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h3333_0000);
    hit(32'h3333_0300);
    // Redirect coincident with the owed response: current target wins over pending.
    step(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 32'h4444_0000);
    hit(32'h5555_0500);
    // Redirect while parked in the hold buffer.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h6666_0504);
    step(1'b0, 1'b1, 1'b1, 32'h600, 1'b0, 32'h0);
    hit(32'h6666_0600);
    // Wrap from the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h7777_0000);
    hit(32'h7777_FFFC);
    hit(32'h7777_0000);
    // Reset while a redirected miss is owed.
    step(1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    hit(32'h8888_0000);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0,
           $urandom() & 32'hFFFF_FFFC,
           $urandom_range(0, 9) < 6,
           $urandom());
    end

    @(negedge clk);
    #5;
    chk("scoreboard_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
